// File: rtl/brick_breaker_pkg.sv
// Shared button-conditioner definitions: button indices and the per-button debounce FSM states.
package brick_breaker_pkg;

    localparam int unsigned BTN_LEFT  = 0;
    localparam int unsigned BTN_RIGHT = 1;
    localparam int unsigned BTN_START = 2;
    localparam int unsigned NUM_BTN   = 3;

    typedef enum logic [1:0] {
        StReleased,
        StPressChk,
        StHeld,
        StReleaseChk
    } btn_state_e;

endpackage

// File: rtl/button_conditioner_if.sv
// One button's raw input and its conditioned level/strobe; all signals active as in the pins.
interface button_conditioner_if;

    logic raw_n;
    logic level_n;
    logic pulse;

    modport master (
        output raw_n,
        input  level_n,
        input  pulse
    );

    modport slave (
        input  raw_n,
        output level_n,
        output pulse
    );

endinterface

// File: rtl/debounce_cell.sv
// Single-button conditioner: two-flop synchronizer, 4-state debounce FSM with counter,
// registered active-low level and one-cycle press strobe.
module debounce_cell
    import brick_breaker_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input logic                 clk,
    input logic                 rst,
    button_conditioner_if.slave btn_if
);

    localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    logic            sync1_q, sync2_q;
    btn_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            pulse_q, pulse_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= StReleased;
            cnt_q   <= '0;
            level_q <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn_if.raw_n;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    // The sample that leaves a stable state counts as the first of the DEBOUNCE_CYCLES run.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        level_d = level_q;
        pulse_d = 1'b0;
        unique case (state_q)
            StReleased: begin
                if (!sync2_q) begin
                    state_d = StPressChk;
                    cnt_d   = CntOne;
                end
            end
            StPressChk: begin
                if (sync2_q) begin
                    state_d = StReleased;
                end else if (cnt_q >= CntLast) begin
                    state_d = StHeld;
                    level_d = 1'b0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHeld: begin
                if (sync2_q) begin
                    state_d = StReleaseChk;
                    cnt_d   = CntOne;
                end
            end
            StReleaseChk: begin
                if (!sync2_q) begin
                    state_d = StHeld;
                end else if (cnt_q >= CntLast) begin
                    state_d = StReleased;
                    level_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StReleased;
        endcase
    end

    assign btn_if.level_n = level_q;
    assign btn_if.pulse   = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Three-button debouncer with press strobes. Define BUTTON_AUTO_REPEAT_EN to add hold-to-repeat
// strobes on left and right; the default build emits exactly one strobe per debounced press.
module button_conditioner
    import brick_breaker_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] key_n,
    output logic       left,
    output logic       right,
    output logic       start,
    output logic       left_pulse,
    output logic       right_pulse,
    output logic       start_pulse
);

    // Shorter settings break the one-idle-cycle guarantee between strobes.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_cfg_check
        $error("button_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD must be >= 2");
    end

    logic [NUM_BTN-1:0] level_n;
    logic [NUM_BTN-1:0] press_pulse;
    logic [NUM_BTN-1:0] out_pulse;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_conditioner_if u_btn_if ();

        assign u_btn_if.raw_n = key_n[i];

        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clk   (clk),
            .rst   (rst),
            .btn_if(u_btn_if.slave)
        );

        assign level_n[i]     = u_btn_if.level_n;
        assign press_pulse[i] = u_btn_if.pulse;
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RptW   = $clog2(RptMax + 1);
    localparam logic [RptW-1:0] DelayLast  = RptW'(REPEAT_DELAY - 1);
    localparam logic [RptW-1:0] PeriodLast = RptW'(REPEAT_PERIOD - 1);

    // Index 0 is left, 1 is right; start never repeats.
    logic [1:0]           first_q, first_d;
    logic [1:0]           rpt_q, rpt_d;
    logic [1:0][RptW-1:0] rpt_cnt_q, rpt_cnt_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            first_q   <= '1;
            rpt_q     <= '0;
            rpt_cnt_q <= '0;
        end else begin
            first_q   <= first_d;
            rpt_q     <= rpt_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

    // Timer runs on the debounced level, so RELEASE_CHK bounces don't restart it.
    always_comb begin
        first_d   = first_q;
        rpt_d     = '0;
        rpt_cnt_d = rpt_cnt_q;
        for (int b = 0; b < 2; b++) begin
            if (level_n[b]) begin
                rpt_cnt_d[b] = '0;
                first_d[b]   = 1'b1;
            end else if (rpt_cnt_q[b] >= (first_q[b] ? DelayLast : PeriodLast)) begin
                rpt_d[b]     = 1'b1;
                rpt_cnt_d[b] = '0;
                first_d[b]   = 1'b0;
            end else begin
                rpt_cnt_d[b] = rpt_cnt_q[b] + 1'b1;
            end
        end
    end

    assign out_pulse[BTN_LEFT]  = press_pulse[BTN_LEFT] | rpt_q[BTN_LEFT];
    assign out_pulse[BTN_RIGHT] = press_pulse[BTN_RIGHT] | rpt_q[BTN_RIGHT];
    assign out_pulse[BTN_START] = press_pulse[BTN_START];
`else
    assign out_pulse = press_pulse;
`endif

    assign left        = level_n[BTN_LEFT];
    assign right       = level_n[BTN_RIGHT];
    assign start       = level_n[BTN_START];
    assign left_pulse  = out_pulse[BTN_LEFT];
    assign right_pulse = out_pulse[BTN_RIGHT];
    assign start_pulse = out_pulse[BTN_START];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random key activity, every cycle
// checked against a run-length reference model of the debounce and repeat rules.
module tb_button_conditioner;
    import brick_breaker_pkg::*;

    localparam int unsigned Deb       = 4;
    localparam int unsigned RptDelay  = 10;
    localparam int unsigned RptPeriod = 3;
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam bit RptOn       = 1'b1;
    localparam int PressPulses = 8;
    localparam int RelPulses   = 2;
`else
    localparam bit RptOn       = 1'b0;
    localparam int PressPulses = 1;
    localparam int RelPulses   = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] key_n;

    button_conditioner_if if_left ();
    button_conditioner_if if_right ();
    button_conditioner_if if_start ();

    assign if_left.raw_n  = key_n[BTN_LEFT];
    assign if_right.raw_n = key_n[BTN_RIGHT];
    assign if_start.raw_n = key_n[BTN_START];

    button_conditioner #(
        .DEBOUNCE_CYCLES(Deb),
        .REPEAT_DELAY   (RptDelay),
        .REPEAT_PERIOD  (RptPeriod)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_n      ({if_start.raw_n, if_right.raw_n, if_left.raw_n}),
        .left       (if_left.level_n),
        .right      (if_right.level_n),
        .start      (if_start.level_n),
        .left_pulse (if_left.pulse),
        .right_pulse(if_right.pulse),
        .start_pulse(if_start.pulse)
    );

    logic [2:0] obs_lvl, obs_pls;
    assign obs_lvl = {if_start.level_n, if_right.level_n, if_left.level_n};
    assign obs_pls = {if_start.pulse, if_right.pulse, if_left.pulse};

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: synced sample = raw seen two edges earlier; level flips after Deb
    // consecutive samples that disagree with it; repeats fall at fixed ages after the press.
    bit [2:0] h1, h2, m_lvl, m_pls;
    int       run [3];
    int       age [3];

    task automatic model_step(input logic [2:0] raw, input logic rst_v);
        bit [2:0] s;
        bit       prev;
        if (!rst_v) begin
            h1 = '1; h2 = '1; m_lvl = '1; m_pls = '0;
            for (int b = 0; b < 3; b++) begin run[b] = 0; age[b] = 0; end
            return;
        end
        s = h2;
        for (int b = 0; b < 3; b++) begin
            prev     = m_lvl[b];
            m_pls[b] = 1'b0;
            run[b]   = (s[b] != m_lvl[b]) ? run[b] + 1 : 0;
            if (run[b] == Deb) begin
                m_lvl[b] = s[b];
                run[b]   = 0;
                if (!s[b]) begin m_pls[b] = 1'b1; age[b] = 0; end
            end
            if (RptOn && b != BTN_START && !prev) begin
                age[b]++;
                if (age[b] >= RptDelay && (age[b] - RptDelay) % RptPeriod == 0) m_pls[b] = 1'b1;
            end
        end
        h2 = h1;
        h1 = raw;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(key_n, rst);
        #1;
        check_val("cycle", {26'd0, obs_pls, obs_lvl}, {26'd0, m_pls, m_lvl});
    endtask

    int first, first_r, cnt, lo_cnt;
    int hold [3];

    initial begin
        rst   = 1'b0;
        key_n = 3'b111;
        repeat (3) tick();
        check_val("reset_state", {26'd0, obs_pls, obs_lvl}, 32'b000111);
        rst = 1'b1;
        repeat (2) tick();

        // Clean left press held 36 edges, then release.
        key_n = 3'b110; first = -1; cnt = 0;
        for (int i = 1; i <= 36; i++) begin
            tick();
            if (obs_pls[0]) begin cnt++; if (first < 0) first = i; end
        end
        check_val("press_lat", first, 6);
        check_val("press_pulses", cnt, PressPulses);
        check_val("held_level", {29'd0, obs_lvl}, 32'b110);
        key_n = 3'b111; first = -1; cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (obs_pls[0]) cnt++;
            if (obs_lvl[0] && first < 0) first = i;
        end
        check_val("release_lat", first, 6);
        check_val("release_pulses", cnt, RelPulses);
        repeat (4) tick();

        // Start bounces 0,1,0,1 at two cycles each, then holds 0.
        cnt = 0; first = -1;
        for (int k = 0; k < 4; k++) begin
            key_n[2] = k[0];
            repeat (2) begin tick(); if (obs_pls[2]) cnt++; end
        end
        key_n[2] = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (obs_pls[2]) begin cnt++; if (first < 0) first = i; end
        end
        check_val("bounce_lat", first, 6);
        check_val("bounce_pulses", cnt, 1);
        key_n = 3'b111;
        repeat (12) tick();

        // Left and right together.
        key_n = 3'b100; first = -1; first_r = -1; lo_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (obs_pls[0] && first < 0) first = i;
            if (obs_pls[1] && first_r < 0) first_r = i;
            if (!obs_lvl[2] || obs_pls[2]) lo_cnt++;
        end
        check_val("simul_left", first, 6);
        check_val("simul_right", first_r, 6);
        check_val("simul_start_idle", lo_cnt, 0);
        key_n = 3'b111;
        repeat (12) tick();

        // One-cycle reset during right PRESS_CHK with the key still down.
        key_n = 3'b101;
        repeat (4) tick();
        rst = 1'b0;
        tick();
        check_val("rst_mid", {26'd0, obs_pls, obs_lvl}, 32'b000111);
        rst = 1'b1; first = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (obs_pls[1] && first < 0) first = i;
        end
        check_val("rst_mid_lat", first, 6);
        key_n = 3'b111;
        repeat (12) tick();

        // Random key activity with occasional resets.
        for (int b = 0; b < 3; b++) hold[b] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    key_n[b] = 1'($urandom_range(0, 1));
                    hold[b]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                          : int'($urandom_range(4, 40));
                end
                hold[b]--;
            end
            rst = ($urandom_range(0, 399) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning stable-input cycles required before a debounced change (20 ms at 50 MHz).
REQ-002 SHALL have parameter REPEAT_DELAY, default 25000000, meaning hold cycles from debounced press to first auto-repeat pulse.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 5000000, meaning cycles between subsequent auto-repeat pulses.
REQ-004 SHALL have port clk, input, 1, meaning the single system clock (50 MHz).
REQ-005 SHALL have port rst, input, 1, meaning reset: synchronous, active-low.
REQ-006 SHALL have port key_n, input, 3, meaning raw asynchronous pushbuttons, active-low; bit0 left, bit1 right, bit2 start.
REQ-007 SHALL have ports left, right and start, each output, 1, meaning debounced levels, active-low, feeding the game top directly.
REQ-008 SHALL have ports left_pulse, right_pulse and start_pulse, each output, 1, meaning one-cycle active-high press (or repeat) strobes.

Function
REQ-009 SHALL pass each key_n bit through a two-flop synchronizer before any other logic.
REQ-010 SHALL run one independent 4-state FSM per button: RELEASED, PRESS_CHK, HELD, RELEASE_CHK.
REQ-011 RELEASED -> PRESS_CHK when the synced input is 0; PRESS_CHK -> RELEASED when it returns to 1 before the count completes, and the counter clears.
REQ-012 PRESS_CHK -> HELD when the synced input has been 0 for DEBOUNCE_CYCLES consecutive cycles; on this edge the level output goes 0 and the pulse asserts for exactly one cycle.
REQ-013 HELD -> RELEASE_CHK when the synced input is 1; RELEASE_CHK -> HELD on any 0 sample (counter clears); RELEASE_CHK -> RELEASED after DEBOUNCE_CYCLES consecutive 1 samples, and the level output returns to 1 with no pulse.
REQ-014 Latency: a clean raw edge SHALL reach the level output exactly DEBOUNCE_CYCLES+2 clock edges later.
REQ-015 Debounce counters SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide; the counter holds 0 in RELEASED and HELD and never wraps.
REQ-016 Buttons SHALL be fully independent; simultaneous presses produce simultaneous pulses, with no arbitration between left and right.
REQ-017 Pulses SHALL never be asserted in two consecutive cycles.

Reset
REQ-018 While rst is 0 at a clk edge: all FSMs go to RELEASED, the synchronizers and counters go to 1/0 (released/zero), left/right/start go to 1, and all pulses go to 0.
REQ-019 Reset mid-press SHALL drop any pending pulse; a button still held after reset release must complete a full PRESS_CHK before it registers.

Configuration
REQ-020 With macro BUTTON_AUTO_REPEAT_EN defined, left and right (not start) SHALL emit an extra pulse once HELD has persisted REPEAT_DELAY cycles, then one every REPEAT_PERIOD cycles while HELD (including across RELEASE_CHK bounces that return to HELD without resetting the repeat timer).
REQ-021 Without BUTTON_AUTO_REPEAT_EN, the repeat timers SHALL NOT be synthesized, and each debounced press SHALL produce exactly one pulse.

Structure
REQ-022 Shared package brick_breaker_pkg SHALL hold the button index constants (BTN_LEFT=0, BTN_RIGHT=1, BTN_START=2) and the button FSM state enum.
REQ-023 SHALL instantiate three copies of the sub-module debounce_cell (synchronizer + FSM + counter + pulse); the auto-repeat logic lives in the top level.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-024 Clean press: key_n[0] 1->0 at cycle 0 -> left=0 and a left_pulse one cycle wide, both at edge 6; release -> left=1 at release+6 with no pulse.
REQ-025 Bounce: key_n[2] toggles 0,1,0,1 every 2 cycles, then holds 0 -> exactly one start_pulse, 6 edges after the final 0.
REQ-026 Simultaneous: key_n 3'b111->3'b100 -> left_pulse and right_pulse in the same cycle, and start stays 1.
REQ-027 Auto-repeat (macro on): left held 30 cycles after the press pulse -> repeat pulses at +10, +13, +16 ... ; with the macro off, exactly one pulse.
REQ-028 Reset mid-operation: rst=0 for 1 cycle during PRESS_CHK with the key still held -> outputs at reset values, and a pulse 6 edges after rst returns to 1.
